// File: rtl/pi_txn_queue_pkg.sv
// Shared constants for the Pi-side posted-transaction queue: register selects,
// command-word bit positions and the packed queue-entry layout.
package pi_txn_pkg;

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_ADDR_LO = 2'd1,
        REG_ADDR_HI = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    // Field positions inside the ADDR_HI command word
    localparam int FC_MSB   = 15;
    localparam int FC_LSB   = 13;
    localparam int RW_BIT   = 9;
    localparam int SIZE_BIT = 8;

    // Packed entry layout, LSB first: fc[2:0], lds_n, uds_n, rw, data[15:0], addr
    localparam int ENT_FC_LSB   = 0;
    localparam int ENT_LDS      = 3;
    localparam int ENT_UDS      = 4;
    localparam int ENT_RW       = 5;
    localparam int ENT_DATA_LSB = 6;
    localparam int ENT_ADDR_LSB = 22;

    function automatic int entry_width(input int aw);
        return aw + 16 + 1 + 2 + 3;
    endfunction

    // Returns {uds_n, lds_n}; a byte cycle selects the lane from address bit 0
    function automatic logic [1:0] strobes_n(input logic is_byte, input logic a0);
        logic [1:0] s;
        if (is_byte) begin
            s = {a0, ~a0};
        end else begin
            s = 2'b00;
        end
        return s;
    endfunction

endpackage

// File: rtl/pi_txn_queue_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, combinational head read and a flush
// that discards everything behind the (possibly just popped) head.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    w_rd_ptr_nxt;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                       (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);
    assign o_rdata   = r_mem[r_rd_ptr[IW-1:0]];

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);
    assign w_rd_ptr_nxt = w_do_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

    // Pointer update; flush collapses the write pointer onto the next read pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            if (i_flush) begin
                r_wr_ptr <= w_rd_ptr_nxt;
            end else if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
        end
    end

    // Entry storage; validity is carried entirely by the pointers
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[IW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/pi_txn_queue.sv
// Pi-side posted-transaction queue: assembles DATA/ADDR_LO/ADDR_HI writes into
// entries, presents the head to the 68k bus engine and tracks read completion.
module pi_txn_queue
    import pi_txn_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 24
) (
    input  logic          PI_CLK,
    input  logic          RST_n,
    input  logic          wr_stb,
    input  logic [1:0]    wr_reg,
    input  logic [15:0]   wr_data,
    input  logic          flush,
    output logic          op_valid,
    output logic [AW-1:0] op_addr,
    output logic [15:0]   op_data,
    output logic          op_rw,
    output logic          op_uds_n,
    output logic          op_lds_n,
    output logic [2:0]    op_fc,
    input  logic          op_ack,
    input  logic          op_done,
    input  logic [15:0]   rd_data_in,
    output logic [15:0]   rd_data,
    output logic          txn_in_progress,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam int EW = entry_width(AW);

    logic [15:0]   r_stg_data;
    logic [15:0]   r_stg_addr_lo;
    logic          r_in_flight;
    logic          r_in_flight_rd;
    logic          r_rd_pending;

    logic          w_commit;
    logic          w_addr_wr;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_rd_done;
    logic          w_nxt_valid;
    logic          w_empty;
    logic          w_full;
    logic [1:0]    w_strb_n;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;

    assign w_commit  = wr_stb && (wr_reg == REG_ADDR_HI);
    assign w_addr_wr = wr_stb && ((wr_reg == REG_ADDR_LO) || (wr_reg == REG_ADDR_HI));
    assign w_pop     = op_ack && op_valid;
    assign w_push    = w_commit && !flush && (!w_full || w_pop);
    assign w_drop    = w_commit && !flush && w_full && !w_pop;
    assign w_rd_done = op_done && r_in_flight && r_in_flight_rd;

    assign w_strb_n = strobes_n(wr_data[SIZE_BIT], r_stg_addr_lo[0]);
    assign w_entry  = {wr_data[AW-17:0], r_stg_addr_lo, r_stg_data,
                       wr_data[RW_BIT], w_strb_n, wr_data[FC_MSB:FC_LSB]};

    // The head being taken (or flushed) must not be re-presented next cycle
    assign w_nxt_valid = !w_empty && !w_pop && !flush;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (PI_CLK),
        .rst_n   (RST_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_wdata (w_entry),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Staging registers for the data word and low address half
    always_ff @(posedge PI_CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_stg_data    <= 16'h0000;
            r_stg_addr_lo <= 16'h0000;
        end else if (wr_stb) begin
            case (wr_reg)
                REG_DATA:    r_stg_data    <= wr_data;
                REG_ADDR_LO: r_stg_addr_lo <= wr_data;
                default: begin
                    r_stg_data    <= r_stg_data;
                    r_stg_addr_lo <= r_stg_addr_lo;
                end
            endcase
        end else begin
            r_stg_data    <= r_stg_data;
            r_stg_addr_lo <= r_stg_addr_lo;
        end
    end

    // Registered view of the queue head presented to the bus engine
    always_ff @(posedge PI_CLK or negedge RST_n) begin
        if (!RST_n) begin
            op_valid <= 1'b0;
            op_addr  <= {AW{1'b0}};
            op_data  <= 16'h0000;
            op_rw    <= 1'b1;
            op_uds_n <= 1'b1;
            op_lds_n <= 1'b1;
            op_fc    <= 3'b111;
        end else begin
            op_valid <= w_nxt_valid;
            if (w_nxt_valid) begin
                op_addr  <= w_head[ENT_ADDR_LSB +: AW];
                op_data  <= w_head[ENT_DATA_LSB +: 16];
                op_rw    <= w_head[ENT_RW];
                op_uds_n <= w_head[ENT_UDS];
                op_lds_n <= w_head[ENT_LDS];
                op_fc    <= w_head[ENT_FC_LSB +: 3];
            end
        end
    end

    // Bus-cycle tracking; a new ack in the same cycle as a done keeps the flag set
    always_ff @(posedge PI_CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_in_flight    <= 1'b0;
            r_in_flight_rd <= 1'b0;
        end else if (w_pop) begin
            r_in_flight    <= 1'b1;
            r_in_flight_rd <= op_rw;
        end else if (op_done) begin
            r_in_flight    <= 1'b0;
            r_in_flight_rd <= 1'b0;
        end else begin
            r_in_flight    <= r_in_flight;
            r_in_flight_rd <= r_in_flight_rd;
        end
    end

    // Read-data capture and outstanding-read flag; a new read commit wins over a completion
    always_ff @(posedge PI_CLK or negedge RST_n) begin
        if (!RST_n) begin
            rd_data      <= 16'h0000;
            r_rd_pending <= 1'b0;
        end else begin
            if (w_rd_done) begin
                rd_data <= rd_data_in;
            end
            if (w_push && wr_data[RW_BIT]) begin
                r_rd_pending <= 1'b1;
            end else if (w_rd_done) begin
                r_rd_pending <= 1'b0;
            end else begin
                r_rd_pending <= r_rd_pending;
            end
        end
    end

    // Sticky overflow and the Pi busy flag
    always_ff @(posedge PI_CLK or negedge RST_n) begin
        if (!RST_n) begin
            overflow        <= 1'b0;
            txn_in_progress <= 1'b0;
        end else begin
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end else begin
                overflow <= overflow;
            end
            txn_in_progress <= w_addr_wr || !w_empty || r_in_flight || r_rd_pending;
        end
    end

endmodule

// File: tb/tb_pi_txn_queue.sv
// Directed scenarios plus randomized traffic against a queue-level reference model.
module tb_pi_txn_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic        rw;
        logic        uds;
        logic        lds;
        logic [2:0]  fc;
    } ent_t;

    logic        PI_CLK = 1'b0;
    logic        RST_n;
    logic        wr_stb;
    logic [1:0]  wr_reg;
    logic [15:0] wr_data;
    logic        flush;
    logic        op_valid;
    logic [23:0] op_addr;
    logic [15:0] op_data;
    logic        op_rw;
    logic        op_uds_n;
    logic        op_lds_n;
    logic [2:0]  op_fc;
    logic        op_ack;
    logic        op_done;
    logic [15:0] rd_data_in;
    logic [15:0] rd_data;
    logic        txn_in_progress;
    logic        overflow;
    logic        ovf_clr;

    int n_cmp = 0;
    int n_bad = 0;

    ent_t        mq[$];
    ent_t        m_head;
    logic        m_valid, m_infl, m_infl_rd, m_rdpend, m_ovf, m_tip;
    logic [15:0] m_rd, m_stg_d, m_stg_a;

    pi_txn_queue #(.DEPTH(DEPTH), .AW(24)) dut (
        .PI_CLK          (PI_CLK),
        .RST_n           (RST_n),
        .wr_stb          (wr_stb),
        .wr_reg          (wr_reg),
        .wr_data         (wr_data),
        .flush           (flush),
        .op_valid        (op_valid),
        .op_addr         (op_addr),
        .op_data         (op_data),
        .op_rw           (op_rw),
        .op_uds_n        (op_uds_n),
        .op_lds_n        (op_lds_n),
        .op_fc           (op_fc),
        .op_ack          (op_ack),
        .op_done         (op_done),
        .rd_data_in      (rd_data_in),
        .rd_data         (rd_data),
        .txn_in_progress (txn_in_progress),
        .overflow        (overflow),
        .ovf_clr         (ovf_clr)
    );

    always #5 PI_CLK = ~PI_CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_head    = '0;
        m_valid   = 1'b0;
        m_infl    = 1'b0;
        m_infl_rd = 1'b0;
        m_rdpend  = 1'b0;
        m_ovf     = 1'b0;
        m_tip     = 1'b0;
        m_rd      = 16'h0000;
        m_stg_d   = 16'h0000;
        m_stg_a   = 16'h0000;
    endtask

    task automatic compare_all();
        check("op_valid", 64'(op_valid), 64'(m_valid));
        if (m_valid)
            check("head", 64'({op_addr, op_data, op_rw, op_uds_n, op_lds_n, op_fc}), 64'(m_head));
        check("rd_data", 64'(rd_data), 64'(m_rd));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("tip", 64'(txn_in_progress), 64'(m_tip));
    endtask

    // One clock: drive inputs, advance the reference model, then compare
    task automatic step(input logic stb, input logic [1:0] rg, input logic [15:0] d,
                        input logic ack, input logic done, input logic [15:0] rdin,
                        input logic fl, input logic oc);
        ent_t e;
        logic pop, commit, full, acc, drop, rdone, nvalid, ntip;
        ent_t nhead;
        wr_stb = stb; wr_reg = rg; wr_data = d; op_ack = ack; op_done = done;
        rd_data_in = rdin; flush = fl; ovf_clr = oc;

        pop    = ack && m_valid;
        commit = stb && (rg == 2'd2);
        full   = (mq.size() == DEPTH);
        acc    = commit && !fl && (!full || pop);
        drop   = commit && !fl && full && !pop;
        rdone  = done && m_infl && m_infl_rd;
        ntip   = (stb && (rg == 2'd1 || rg == 2'd2)) || (mq.size() != 0) || m_infl || m_rdpend;
        nvalid = (mq.size() != 0) && !pop && !fl;
        nhead  = nvalid ? mq[0] : m_head;

        e.addr = {d[7:0], m_stg_a};
        e.data = m_stg_d;
        e.rw   = d[9];
        e.fc   = d[15:13];
        e.uds  = d[8] ? m_stg_a[0] : 1'b0;
        e.lds  = d[8] ? ~m_stg_a[0] : 1'b0;

        if (rdone) m_rd = rdin;
        if (acc && d[9]) m_rdpend = 1'b1;
        else if (rdone)  m_rdpend = 1'b0;
        if (pop) begin
            m_infl    = 1'b1;
            m_infl_rd = mq[0].rw;
            void'(mq.pop_front());
        end else if (done) begin
            m_infl    = 1'b0;
        end
        if (fl)  mq.delete();
        if (acc) mq.push_back(e);
        if (drop)    m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        if (stb && rg == 2'd0) m_stg_d = d;
        if (stb && rg == 2'd1) m_stg_a = d;
        m_valid = nvalid;
        m_head  = nhead;
        m_tip   = ntip;

        @(posedge PI_CLK);
        #1;
        compare_all();
    endtask

    task automatic wr(input logic [1:0] rg, input logic [15:0] d);
        step(1'b1, rg, d, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic ack();
        step(1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic done(input logic [15:0] rdin);
        step(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, rdin, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(op_valid), 64'd0);
        check({tag, "_ctl"}, 64'({op_rw, op_uds_n, op_lds_n, op_fc}), 64'h3F);
        check({tag, "_flags"}, 64'({txn_in_progress, overflow}), 64'd0);
        check({tag, "_rd"}, 64'(rd_data), 64'd0);
    endtask

    initial begin
        logic [15:0] last;
        int          pops;

        RST_n = 1'b0; wr_stb = 1'b0; wr_reg = 2'd0; wr_data = 16'h0000; flush = 1'b0;
        op_ack = 1'b0; op_done = 1'b0; rd_data_in = 16'h0000; ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge PI_CLK);
        #1;
        check_reset_outputs("reset");
        RST_n = 1'b1;

        // Word write
        wr(2'd0, 16'hBEEF);
        wr(2'd1, 16'h1234);
        wr(2'd2, 16'h0056);
        check("word_lat0", 64'(op_valid), 64'd0);
        idle();
        check("word_lat1", 64'(op_valid), 64'd1);
        check("word_addr", 64'(op_addr), 64'h561234);
        check("word_data", 64'(op_data), 64'hBEEF);
        check("word_ctl", 64'({op_rw, op_uds_n, op_lds_n}), 64'd0);
        ack();
        done(16'h0000);
        idle();

        // Byte read at an odd address
        wr(2'd1, 16'h0001);
        wr(2'd2, 16'hA300);
        idle();
        check("rd_fc", 64'(op_fc), 64'd5);
        check("rd_ctl", 64'({op_rw, op_uds_n, op_lds_n}), 64'b110);
        ack();
        done(16'h00C3);
        check("rd_data_c3", 64'(rd_data), 64'h00C3);
        check("rd_tip_hold", 64'(txn_in_progress), 64'd1);
        idle();
        check("rd_tip_fall", 64'(txn_in_progress), 64'd0);

        // Fill past capacity
        for (int i = 1; i <= 5; i++) begin
            wr(2'd1, 16'(i * 2));
            wr(2'd2, 16'h0000);
        end
        idle();
        check("ovf_set", 64'(overflow), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            check("fill_order", 64'(op_addr[15:0]), 64'(i * 2));
            ack();
            done(16'h0000);
        end
        check("fill_empty", 64'(op_valid), 64'd0);
        step(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        check("ovf_clr", 64'(overflow), 64'd0);

        // Full with simultaneous commit and ack
        for (int i = 0; i < 4; i++) begin
            wr(2'd1, 16'(16'h0010 + i));
            wr(2'd2, 16'h0000);
        end
        idle();
        wr(2'd1, 16'h0099);
        step(1'b1, 2'd2, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("simul_ovf", 64'(overflow), 64'd0);
        done(16'h0000);
        last = 16'h0000;
        pops = 0;
        for (int k = 0; k < 8; k++) begin
            if (op_valid) begin
                last = op_addr[15:0];
                pops++;
                ack();
                done(16'h0000);
            end else begin
                idle();
            end
        end
        check("simul_count", 64'(pops), 64'd4);
        check("simul_last", 64'(last), 64'h0099);

        // Flush while a cycle is in flight
        for (int i = 0; i < 3; i++) begin
            wr(2'd1, 16'(16'h0100 + i));
            wr(2'd2, 16'h0000);
        end
        idle();
        ack();
        step(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("flush_valid", 64'(op_valid), 64'd0);
        repeat (3) idle();
        check("flush_tip_hold", 64'(txn_in_progress), 64'd1);
        done(16'h0000);
        idle();
        check("flush_tip_fall", 64'(txn_in_progress), 64'd0);

        // Asynchronous reset between edges
        wr(2'd1, 16'h0200);
        wr(2'd2, 16'h0012);
        wr(2'd2, 16'h0034);
        idle();
        #3;
        RST_n = 1'b0;
        #1;
        check_reset_outputs("areset");
        model_reset();
        @(posedge PI_CLK);
        #1;
        RST_n = 1'b1;
        repeat (3) idle();
        check("areset_stale", 64'(op_valid), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic        r_stb, r_ack, r_done, r_fl, r_oc;
            logic [1:0]  r_rg;
            logic [15:0] r_d, r_rdin;
            r_stb  = ($urandom_range(99) < 50);
            r_rg   = 2'($urandom_range(3));
            r_d    = 16'($urandom);
            r_ack  = ($urandom_range(99) < 35);
            r_done = m_infl ? ($urandom_range(99) < 50) : ($urandom_range(99) < 5);
            r_rdin = 16'($urandom);
            r_fl   = ($urandom_range(99) < 3);
            r_oc   = ($urandom_range(99) < 5);
            step(r_stb, r_rg, r_d, r_ack, r_done, r_rdin, r_fl, r_oc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
